// File: rtl/branch_update_queue.sv
// ---------------------------------------------------------------------------
// branch_update_queue
//
// Collects branch-resolution records from the two issue lanes and feeds them
// to the branch predictor's single update port, one record per cycle. Bursts
// are buffered in a small in-order FIFO. The predictor only uses these
// records as training hints, so the pipeline is never stalled. When the FIFO
// has no room, the newest records are discarded and counted.
//
// Record layout (REC_W = 72 bits):
//   [0]      valid
//   [1]      taken
//   [2]      mispredict
//   [4:3]    counter
//   [7:5]    cf (control-flow kind)
//   [39:8]   pc
//   [71:40]  target
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   resolved_i   two packed records; the low record is lane 0 (older)
//   upd_o        record at the FIFO head, presented to the predictor
//   upd_valid_o  upd_o holds a valid record
//   upd_ready_i  predictor accepts upd_o this cycle
//   count_o      current occupancy
//   full_o       occupancy equals DEPTH
//   drop_cnt_o   saturating count of discarded records
// ---------------------------------------------------------------------------
module branch_update_queue #(
    parameter int DEPTH     = 4,
    parameter int CNT_WIDTH = 16,
    localparam int REC_W    = 72,
    localparam int PW       = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2*REC_W-1:0]   resolved_i,
    output logic [REC_W-1:0]     upd_o,
    output logic                 upd_valid_o,
    input  logic                 upd_ready_i,
    output logic [PW:0]          count_o,
    output logic                 full_o,
    output logic [CNT_WIDTH-1:0] drop_cnt_o
);

    logic [REC_W-1:0]     mem [DEPTH];
    logic [PW-1:0]        head;
    logic [PW-1:0]        tail;
    logic [PW-1:0]        tail_p1;
    logic [PW:0]          count;
    logic [CNT_WIDTH-1:0] drop_cnt;
    logic [CNT_WIDTH:0]   drop_sum;

    logic [REC_W-1:0]     rec0;
    logic [REC_W-1:0]     rec1;
    logic [REC_W-1:0]     first_rec;
    logic [PW:0]          free;
    logic [1:0]           cand;
    logic [1:0]           enq_n;
    logic [1:0]           drop_n;
    logic                 deq;

    // Enqueue decision. Free space is taken from the occupancy before this
    // cycle's dequeue, so a slot being vacated this cycle cannot be reused
    // until the next cycle. When there is room for only one of two
    // candidates, the older lane-0 record wins and lane 1 is dropped.
    always_comb begin
        rec0      = resolved_i[REC_W-1:0];
        rec1      = resolved_i[2*REC_W-1:REC_W];
        cand      = {1'b0, rec0[0]} + {1'b0, rec1[0]};
        free      = (PW+1)'(DEPTH) - count;
        if (free >= (PW+1)'(cand)) begin
            enq_n = cand;
        end else begin
            // free < cand <= 2 here, so free fits in two bits
            enq_n = free[1:0];
        end
        drop_n    = cand - enq_n;
        // A lone lane-1 record still lands in the tail slot
        first_rec = rec0[0] ? rec0 : rec1;
        tail_p1   = tail + PW'(1);
        deq       = (count != '0) && upd_ready_i;
        // One extra bit catches the step past the saturation limit
        drop_sum  = {1'b0, drop_cnt} + (CNT_WIDTH+1)'(drop_n);
    end

    // Entry storage carries no reset; only the pointers and occupancy
    // decide which slots hold live records. A dual enqueue writes lane 1 to
    // the slot after tail, which wraps naturally because DEPTH is a power
    // of two.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (enq_n != 2'd0) begin
                mem[tail] <= first_rec;
            end
            if (enq_n == 2'd2) begin
                mem[tail_p1] <= rec1;
            end
        end
    end

    // Pointer, occupancy and drop-counter state. Enqueue and dequeue in the
    // same cycle are both applied to the occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            drop_cnt <= '0;
        end else begin
            if (deq) begin
                head <= head + PW'(1);
            end
            tail  <= tail + PW'(enq_n);
            count <= count + (PW+1)'(enq_n) - (PW+1)'(deq);
            if (drop_sum[CNT_WIDTH]) begin
                drop_cnt <= '1;
            end else begin
                drop_cnt <= drop_sum[CNT_WIDTH-1:0];
            end
        end
    end

    assign upd_o       = mem[head];
    assign upd_valid_o = (count != '0);
    assign count_o     = count;
    assign full_o      = (count == (PW+1)'(DEPTH));
    assign drop_cnt_o  = drop_cnt;

endmodule
